// File: rtl/jpeg_dezigzag_pkg.sv
// Shared constants for the inverse-zigzag reorder buffer.
package jpeg_dezigzag_pkg;

   localparam int         BLK_SIZE = 64;
   localparam int         IDX_W    = 6;
   localparam logic [5:0] LAST_IDX = 6'(BLK_SIZE - 1);

   // Raster position of the k-th coefficient in standard JPEG zigzag order.
   localparam logic [5:0] ZZ_TO_RASTER [0:63] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

endpackage

// File: rtl/jpeg_dezigzag_bank.sv
// One 64-entry coefficient bank: single write port, combinational read port.
module jpeg_dezigzag_bank
   import jpeg_dezigzag_pkg::*;
#(
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [IDX_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [BLK_SIZE];

   // Store one coefficient per write strobe.
   // NOTE: storage has no reset; the full flags in the parent decide what is valid,
   // and leaving the array out of reset keeps it a plain register file.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jpeg_dezigzag.sv
// Inverse zigzag reorder buffer: zigzag-order input, raster-order output,
// two ping-pong banks so one block fills while the other drains.
module jpeg_dezigzag
   import jpeg_dezigzag_pkg::*;
#(
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [2:0]        out_row,
   output logic [2:0]        out_col,
   output logic              out_last,
   output logic              err_frame
);

   logic [1:0]        bank_full_q, bank_full_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic [IDX_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic              err_frame_q, err_frame_d;

   logic              wr_fire, rd_fire;
   logic              wr_at_end, rd_at_end;
   logic [IDX_W-1:0]  wr_addr;
   logic [DATA_W-1:0] bank_rdata [2];

   // Handshakes depend only on registered flags, so in_ready never sees out_ready.
   assign in_ready  = ~bank_full_q[wr_bank_q];
   assign out_valid = bank_full_q[rd_bank_q];
   assign wr_fire   = in_valid & in_ready;
   assign rd_fire   = out_valid & out_ready;
   assign wr_at_end = (wr_cnt_q == LAST_IDX);
   assign rd_at_end = (rd_cnt_q == LAST_IDX);
   assign wr_addr   = ZZ_TO_RASTER[wr_cnt_q];

   assign out_data  = bank_rdata[rd_bank_q];
   assign out_row   = rd_cnt_q[5:3];
   assign out_col   = rd_cnt_q[2:0];
   assign out_last  = out_valid & rd_at_end;
   assign err_frame = err_frame_q;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      jpeg_dezigzag_bank #(.DATA_W(DATA_W)) u_bank (
         .clk     (clk),
         .we_i    (wr_fire && (wr_bank_q == 1'(b))),
         .waddr_i (wr_addr),
         .wdata_i (in_data),
         .raddr_i (rd_cnt_q),
         .rdata_o (bank_rdata[b])
      );
   end

   // Next-state for bank flags, pointers, counters and the framing check.
   // NOTE: every _d gets a default from its _q first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      bank_full_d = bank_full_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      err_frame_d = 1'b0;

      // Fill side: counters wrap naturally at 64; the last beat seals the bank.
      if (wr_fire) begin
         wr_cnt_d    = wr_cnt_q + 6'd1;
         err_frame_d = (in_last != wr_at_end);
         if (wr_at_end) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
         end
      end

      // Drain side: the filling bank is never full, so the two flag updates
      // always touch different bits.
      if (rd_fire) begin
         rd_cnt_d = rd_cnt_q + 6'd1;
         if (rd_at_end) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
         end
      end
   end

   // Control state registers; reset discards any partial block.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_full_q <= 2'b00;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         err_frame_q <= 1'b0;
      end else begin
         bank_full_q <= bank_full_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         err_frame_q <= err_frame_d;
      end
   end

endmodule
